// File: rtl/dbg_display_mux.sv
// Debug display mux: picks one of NCH channels for a 7-segment driver (manual, timed/stepped scan, freeze).
// Latency: outputs are registered, one edge after the sampled inputs.
// Backpressure: none; the display consumes every cycle.
module dbg_display_mux #(
  parameter int NCH        = 8,
  parameter int W          = 32,
  parameter int SELW       = 3,
  parameter int SCAN_TICKS = 100000000,
  parameter int HOLD_EN    = 1
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic [NCH*W-1:0]    ch_data,
  input  logic [NCH-1:0]      ch_valid,
  input  logic [SELW-1:0]     sel,
  input  logic [1:0]          mode,
  input  logic                step,
  output logic [31:0]         disp_data,
  output logic [SELW-1:0]     disp_ch,
  output logic                disp_valid,
  output logic                scan_tick
);

  localparam int CW = $clog2(SCAN_TICKS);

  typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_FROZEN} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [31:0]       disp_data_q;
  logic [SELW-1:0]   disp_ch_q;
  logic              disp_vld_q;

  logic [SELW-1:0]   sel_c;
  logic [SELW-1:0]   idx_inc;
  logic [SELW-1:0]   cur;
  logic [NCH*W-1:0]  src_data;
  logic [NCH-1:0]    src_vld;
  logic [W-1:0]      cur_data;
  logic              cur_vld;

  // Out-of-range indices fall back to channel 0; the index wraps NCH-1 -> 0
  assign sel_c   = (32'(sel) < NCH) ? sel : '0;
  assign idx_inc = (32'(idx_q) == NCH - 1) ? '0 : idx_q + SELW'(1);

  if (HOLD_EN != 0) begin : g_hold
    logic [NCH*W-1:0] hold_q, hold_d;
    logic [NCH-1:0]   seen_q, seen_d;

    // Capture every valid sample; seen marks channels that have ever delivered one
    always_comb begin
      hold_d = hold_q;
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i]) hold_d[i*W +: W] = ch_data[i*W +: W];
      end
      seen_d = seen_q | ch_valid;
    end

    // Hold registers keep loading in every state, including freeze
    always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
        seen_q <= '0;
      end else begin
        hold_q <= hold_d;
        seen_q <= seen_d;
      end
    end

    // Display sees the value after this edge's load, so a sample shows one cycle later
    assign src_data = hold_d;
    assign src_vld  = seen_d;
  end else begin : g_nohold
    // Without hold, a channel shows its live data only while valid, zero otherwise
    always_comb begin
      src_data = '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i]) src_data[i*W +: W] = ch_data[i*W +: W];
      end
    end
    assign src_vld = ch_valid;
  end

  // Current-cycle state follows mode directly; 11 behaves as manual
  always_comb begin
    case (mode)
      2'b01:   state_d = ST_SCAN;
      2'b10:   state_d = ST_FROZEN;
      default: state_d = ST_MANUAL;
    endcase
  end

  // Scan index/counter control and choice of displayed channel
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    cur    = sel_c;
    if (state_d == ST_SCAN) begin
      if (state_q != ST_SCAN) begin
        idx_d = sel_c;
        cnt_d = '0;
      end else if (cnt_q == CW'(SCAN_TICKS - 1)) begin
        idx_d  = idx_inc;
        cnt_d  = '0;
        tick_d = 1'b1;
      end else if (step) begin
        idx_d = idx_inc;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      cur = idx_d;
    end
  end

  // Channel mux on the current index
  always_comb begin
    cur_data = '0;
    cur_vld  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(cur) == i) begin
        cur_data = src_data[i*W +: W];
        cur_vld  = src_vld[i];
      end
    end
  end

  // State, scan registers and display registers; freeze simply stops the display loading
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_MANUAL;
      idx_q       <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      disp_data_q <= '0;
      disp_ch_q   <= '0;
      disp_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      if (state_d != ST_FROZEN) begin
        disp_data_q <= 32'(cur_data);
        disp_ch_q   <= cur;
        disp_vld_q  <= cur_vld;
      end
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_ch    = disp_ch_q;
  assign disp_valid = disp_vld_q;
  assign scan_tick  = tick_q;

endmodule
